ddr3_pattern_loader: RTL

Bulk copier that moves a DMD pattern block from DDR3 into the on-chip pattern memory. The pattern fetch stage reads that memory to build the HDMI pixel stream. On a start pulse the loader issues burst reads on the DDR3 EMIF Avalon-MM port and writes each returned 256-bit word into the on-chip memory write port at consecutive addresses. It sits directly upstream of the video pattern generator and fills the memory the generator's fetch logic consumes.

---
 rtl/ddr3_pattern_loader.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ddr3_pattern_loader.sv
// Copies a block of 256-bit words from DDR3 (Avalon-MM burst reads) into the
// on-chip pattern memory feeding the video pattern generator's fetch logic.
module ddr3_pattern_loader #(
  parameter int BURST_LEN = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [21:0]  src_addr,
  input  logic [10:0]  dst_addr,
  input  logic [11:0]  num_words,
  output logic         busy,
  output logic         done,
  input  logic         ddr3_emif_ready,
  output logic         ddr3_emif_read,
  output logic         ddr3_emif_write,
  output logic [21:0]  ddr3_emif_addr,
  output logic [4:0]   ddr3_emif_burst_count,
  output logic [255:0] ddr3_emif_write_data,
  output logic [31:0]  ddr3_emif_byte_enable,
  input  logic [255:0] ddr3_emif_read_data,
  input  logic         ddr3_emif_rddata_valid,
  output logic         onchip_mem_chip_select,
  output logic         onchip_mem_clken,
  output logic         onchip_mem_write,
  output logic [10:0]  onchip_mem_addr,
  output logic [255:0] onchip_mem_write_data,
  output logic [31:0]  onchip_mem_byte_enable
);

  // Avalon-MM read handshake: a command transfers on any clock edge where
  // ddr3_emif_read and ddr3_emif_ready are both high; while ready is low the
  // command (read, addr, burst_count) is held unchanged.
  typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [11:0] req_left;
  logic [11:0] rcv_left;
  logic [10:0] wr_ptr;
  logic [11:0] num_sat;
  logic [11:0] req_left_after;
  logic        load_accept;
  logic        cmd_accept;
  logic        data_take;
  logic        last_data;

  function automatic logic [4:0] burst_of(input logic [11:0] left);
    if (left > 12'(BURST_LEN)) return 5'(BURST_LEN);
    else return left[4:0];
  endfunction

  assign num_sat        = (num_words > 12'd2048) ? 12'd2048 : num_words;
  assign load_accept    = (state == IDLE) && start && (num_sat != 12'd0);
  assign cmd_accept     = (state == REQ) && ddr3_emif_read && ddr3_emif_ready;
  assign req_left_after = req_left - {7'd0, ddr3_emif_burst_count};
  assign data_take      = ((state == REQ) || (state == WAIT_DATA)) && ddr3_emif_rddata_valid;
  assign last_data      = data_take && (rcv_left == 12'd1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = (num_sat == 12'd0) ? DONE : REQ;
      end
      REQ: begin
        if (last_data)                                       state_next = DONE;
        else if (cmd_accept && (req_left_after == 12'd0))    state_next = WAIT_DATA;
      end
      WAIT_DATA: begin
        // rcv_left==0 here would mean a lost count; leave rather than hang.
        if (last_data || (rcv_left == 12'd0)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command side: the registered command outputs double as the request pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ddr3_emif_read        <= 1'b0;
      ddr3_emif_addr        <= 22'd0;
      ddr3_emif_burst_count <= 5'd0;
      req_left              <= 12'd0;
    end else begin
      if (load_accept) begin
        ddr3_emif_read        <= 1'b1;
        ddr3_emif_addr        <= src_addr;
        ddr3_emif_burst_count <= burst_of(num_sat);
        req_left              <= num_sat;
      end else if (cmd_accept) begin
        ddr3_emif_read        <= (req_left_after != 12'd0);
        ddr3_emif_addr        <= ddr3_emif_addr + 22'(ddr3_emif_burst_count);
        ddr3_emif_burst_count <= burst_of(req_left_after);
        req_left              <= req_left_after;
      end
      if (state_next == DONE) ddr3_emif_read <= 1'b0;
    end
  end

  // Data side: one-cycle registered write of each returned word.
  always_ff @(posedge clk) begin
    if (rst) begin
      onchip_mem_write      <= 1'b0;
      onchip_mem_addr       <= 11'd0;
      onchip_mem_write_data <= 256'd0;
      wr_ptr                <= 11'd0;
      rcv_left              <= 12'd0;
    end else begin
      onchip_mem_write <= data_take;
      if (load_accept) begin
        wr_ptr   <= dst_addr;
        rcv_left <= num_sat;
      end else if (data_take) begin
        onchip_mem_write_data <= ddr3_emif_read_data;
        onchip_mem_addr       <= wr_ptr;
        wr_ptr                <= wr_ptr + 11'd1;
        rcv_left              <= rcv_left - 12'd1;
      end
    end
  end

  // done trails the DONE state by one cycle, i.e. the cycle after the last write.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state == DONE);
    end
  end

  assign ddr3_emif_write        = 1'b0;
  assign ddr3_emif_write_data   = 256'd0;
  assign ddr3_emif_byte_enable  = {32{1'b1}};
  assign onchip_mem_chip_select = 1'b1;
  assign onchip_mem_clken       = 1'b1;
  assign onchip_mem_byte_enable = {32{1'b1}};

endmodule
